clk_div_monitor: RTL

- Receive-side companion to the on-chip clock divider: takes one divided-clock tap (clk_div2/4/8/16 style) and measures its period in units of clk.
- Checks the period against an expected value; reports lock, mismatch and stall (timeout).
- Sits beside the divider in the top-level tile; feeds status bits to spare uo_out/uio_out pins, or forms a loopback self-test when the tap is routed back in through ui_in.

---
 rtl/clk_div_monitor_pkg.sv | 17 +
 rtl/clk_div_edge_sync.sv | 39 +++
 rtl/clk_div_monitor.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/clk_div_monitor_pkg.sv
// Shared definitions for the divided-clock period monitor.
// Holds the FSM state encoding and the default counter width so the wrapper,
// the divider and the monitor agree on one value.
package clk_div_monitor_pkg;

  localparam int unsigned CntWDefault      = 8;
  localparam int unsigned LockCountDefault = 4;

  // Encoding is visible on state_out, so the values are fixed.
  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWaitFirst = 2'd1,
    StMeasure   = 2'd2,
    StLocked    = 2'd3
  } mon_state_e;

endpackage

// File: rtl/clk_div_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous tap.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high; clears all flops
//   sig_in - asynchronous input signal
//   rise   - high for one cycle after a synchronized 0->1 transition
// A transition sampled at edge k shows up on rise during the cycle after edge k+1.
module clk_div_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = sig_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures the period of a divided-clock tap in clk cycles, compares it with
// expected_period and reports lock, mismatch and stall (timeout).
// Ports:
//   clk, reset       - system clock; synchronous active-high reset
//   enable           - run measurement; low forces IDLE
//   sig_in           - monitored divided clock (asynchronous)
//   expected_period  - expected period in clk cycles, sampled on each measured edge
//   clr_flags        - pulse; clears the sticky mismatch/timeout flags
//   period_out       - last measured period
//   period_valid     - one-cycle pulse when period_out updates
//   locked           - registered, high in LOCKED
//   mismatch/timeout - sticky status flags
//   state_out        - current FSM state encoding
module clk_div_monitor
  import clk_div_monitor_pkg::*;
#(
  parameter int unsigned CNT_W      = CntWDefault,
  parameter int unsigned LOCK_COUNT = LockCountDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] expected_period,
  input  logic             clr_flags,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             locked,
  output logic             mismatch,
  output logic             timeout,
  output logic [1:0]       state_out
);

  localparam logic [CNT_W-1:0] CntOne    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax    = '1;
  // Stepping from here into CntMax is the saturation event. A rise in that
  // same cycle is a period of exactly CntMax and wins over the timeout.
  localparam logic [CNT_W-1:0] CntSatPre = CntMax - CntOne;
  localparam logic [3:0]       LockCnt   = 4'(LOCK_COUNT);

  logic rise;

  clk_div_edge_sync u_edge_sync (
    .clk    (clk),
    .reset  (reset),
    .sig_in (sig_in),
    .rise   (rise)
  );

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       match_q, match_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             mismatch_q, mismatch_d;
  logic             timeout_q, timeout_d;

  logic [CNT_W-1:0] meas;
  logic [3:0]       match_inc;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    match_d    = match_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    // Clear first so that a set later in this block takes priority.
    mismatch_d = clr_flags ? 1'b0 : mismatch_q;
    timeout_d  = clr_flags ? 1'b0 : timeout_q;
    meas       = cnt_q + CntOne;
    match_inc  = match_q + 4'd1;

    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
      match_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d   = '0;
          match_d = '0;
          state_d = StWaitFirst;
        end
        StWaitFirst: begin
          if (rise) begin
            cnt_d   = '0;
            state_d = StMeasure;
          end else if (cnt_q == CntSatPre) begin
            cnt_d     = CntMax;
            timeout_d = 1'b1;
          end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntOne;
          end
          // Parked at CntMax after a stall: hold without re-flagging, so
          // clr_flags can clear timeout while the tap is still dead.
        end
        StMeasure, StLocked: begin
          if (rise) begin
            cnt_d    = '0;
            period_d = meas;
            valid_d  = 1'b1;
            if (meas == expected_period) begin
              if (state_q == StMeasure) begin
                match_d = match_inc;
                if (match_inc == LockCnt) begin
                  state_d = StLocked;
                end
              end
            end else begin
              mismatch_d = 1'b1;
              match_d    = '0;
              state_d    = StMeasure;
            end
          end else if (cnt_q == CntSatPre) begin
            cnt_d     = CntMax;
            timeout_d = 1'b1;
            match_d   = '0;
            state_d   = StWaitFirst;
          end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Registered from next state so locked never glitches on a state decode.
    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      match_q    <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      match_q    <= match_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      mismatch_q <= mismatch_d;
      timeout_q  <= timeout_d;
    end
  end

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;
  assign mismatch     = mismatch_q;
  assign timeout      = timeout_q;
  assign state_out    = state_q;

endmodule
